// File: rtl/sram_param.sv
// sram_param: parametrised single-port synchronous SRAM with per-lane write
// enables, 1- or 2-cycle registered read latency, an out-of-range error strobe
// and a sequential clear engine that zeroes the array after reset.
//
// Ports:
//   Clk      - clock, rising edge
//   Rst      - synchronous active-high reset; restarts the clear sequence
//   En       - request strobe (one request per cycle)
//   Rw       - 1 = write, 0 = read
//   Addr     - word address
//   Be       - lane write enables (writes only)
//   Data_in  - write data
//   Data_out - read data; holds its last value between reads
//   Valid    - one-cycle pulse when Data_out carries new read data
//   Busy     - high while the clear engine runs; requests are ignored
//   Err      - one-cycle pulse for an accepted request with Addr >= DEPTH
module sram_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LANE_W   = 8,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DEPTH    = 32768,
  parameter int unsigned READ_LAT = 1,
  localparam int unsigned LANES   = DATA_W / LANE_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              Rw,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [LANES-1:0]  Be,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Valid,
  output logic              Busy,
  output logic              Err
);

  // Array index width; Addr is range-checked before it is used as an index.
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e state_q, state_d;
  // One bit wider than Addr so it cannot wrap when DEPTH == 2**ADDR_W.
  logic [ADDR_W:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, in_range, rd_hit;
  logic              mem_we;
  logic [IdxW-1:0]   mem_addr;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // Stage between issue and output; only used when READ_LAT == 2.
  logic              pipe_valid_q, pipe_valid_d;
  logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  // Request decode
  always_comb begin
    accept   = En && (state_q == StRun) && !Rst;
    in_range = {1'b0, Addr} < DepthW;
    rd_hit   = accept && !Rw && in_range;
    rd_word  = mem_q[Addr[IdxW-1:0]];
  end

  // Clear FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (Rst) begin
      state_d = StClear;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LastPtr) begin
            state_d = StRun;
          end
        end
        StRun: ;
        default: state_d = StClear;
      endcase
    end
  end

  // Memory write port, shared between the clear engine and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = Addr[IdxW-1:0];
    mem_be    = Be;
    mem_wdata = Data_in;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q[IdxW-1:0];
      mem_be    = '1;
      mem_wdata = '0;
    end else if (accept && Rw && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Read pipeline and strobes
  always_comb begin
    pipe_valid_d = 1'b0;
    pipe_data_d  = pipe_data_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    data_out_d   = data_out_q;
    if (Rst) begin
      data_out_d = '0;
    end else begin
      err_d = accept && !in_range;
      if (READ_LAT == 2) begin
        pipe_valid_d = rd_hit;
        if (rd_hit) begin
          pipe_data_d = rd_word;
        end
        valid_d = pipe_valid_q;
        if (pipe_valid_q) begin
          data_out_d = pipe_data_q;
        end
      end else begin
        valid_d = rd_hit;
        if (rd_hit) begin
          data_out_d = rd_word;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StClear;
      ptr_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      data_out_q   <= data_out_d;
    end
  end

  // Array storage carries no reset; the clear engine zeroes it word by word.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign Data_out = data_out_q;
  assign Valid    = valid_q;
  assign Err      = err_q;
  assign Busy     = (state_q == StClear);

endmodule
